// File: rtl/registro_resultado_if.sv
// Valid/ready handshake bundle between the adder, the result register stage
// and the downstream consumer.
interface registro_resultado_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_c;
    logic [3:0]   in_banderas;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_c;
    logic [3:0]   out_banderas;

    modport slave (
        input  in_valid, in_c, in_banderas, out_ready,
        output in_ready, out_valid, out_c, out_banderas
    );

    modport master (
        output in_valid, in_c, in_banderas, out_ready,
        input  in_ready, out_valid, out_c, out_banderas
    );
endinterface

// File: rtl/registro_resultado.sv
// Registered output stage behind the adder: 2-entry skid buffer carrying the
// result and flags, plus sticky flags and saturating event counters.
module registro_resultado #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    registro_resultado_if.slave bus,
    input  logic             clr,
    output logic [3:0]       sticky,
    output logic [CNT_W-1:0] count_ops,
    output logic [CNT_W-1:0] count_carry
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state;
    logic [N-1:0] head_c, tail_c;
    logic [3:0]   head_b, tail_b;
    logic         in_ready_q, out_valid_q;
    logic         in_fire, out_fire;

    assign in_fire          = bus.in_valid & in_ready_q;
    assign out_fire         = out_valid_q & bus.out_ready;
    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_c        = head_c;
    assign bus.out_banderas = head_b;

    // The head register drives out_* directly, so it only changes on a pop or
    // on a load into an empty/draining slot -- never while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            // NOTE: both entries are cleared so no stale result can surface after reset.
            head_c      <= '0;
            head_b      <= '0;
            tail_c      <= '0;
            tail_b      <= '0;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values of its peers.
            case (state)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (in_fire) begin
                        head_c      <= bus.in_c;
                        head_b      <= bus.in_banderas;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    case ({in_fire, out_fire})
                        2'b10: begin
                            tail_c     <= bus.in_c;
                            tail_b     <= bus.in_banderas;
                            in_ready_q <= 1'b0;
                            state      <= FULL;
                        end
                        2'b01: begin
                            out_valid_q <= 1'b0;
                            state       <= EMPTY;
                        end
                        2'b11: begin
                            head_c <= bus.in_c;
                            head_b <= bus.in_banderas;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (out_fire) begin
                        head_c     <= tail_c;
                        head_b     <= tail_b;
                        in_ready_q <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= EMPTY;
                end
            endcase
        end
    end

    // A clear coinciding with an accept restarts accumulation from that entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky      <= '0;
            count_ops   <= '0;
            count_carry <= '0;
        end else if (clr) begin
            if (in_fire) begin
                sticky      <= bus.in_banderas;
                count_ops   <= CNT_W'(1);
                count_carry <= CNT_W'(bus.in_banderas[1]);
            end else begin
                sticky      <= '0;
                count_ops   <= '0;
                count_carry <= '0;
            end
        end else if (in_fire) begin
            sticky <= sticky | bus.in_banderas;
            if (count_ops != '1)
                count_ops <= count_ops + CNT_W'(1);
            if (bus.in_banderas[1] && (count_carry != '1))
                count_carry <= count_carry + CNT_W'(1);
        end
    end

endmodule

// File: doc/registro_resultado.md
Name: registro_resultado

Overview:
- Registered output stage placed directly downstream of the N-bit adder (sumador).
- Captures the adder's result c[N-1:0] and its flags banderas[3:0] (N,Z,C,V) through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Keeps sticky flags (OR of all accepted flags) and saturating counters for accepted operations and carry events, for the display/control logic.

Parameters:
N, 4, data width; must match the upstream adder's n
CNT_W, 8, width of both event counters

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream result/flags valid
in_ready  output  1  stage can accept; registered
in_c  input  N  adder result
in_banderas  input  4  [3]=N, [2]=Z, [1]=C, [0]=V
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head
out_c  output  N  head entry result
out_banderas  output  4  head entry flags
sticky  output  4  OR of in_banderas over all accepted entries since last clear
clr  input  1  synchronous clear of sticky and counters
count_ops  output  CNT_W  accepted entries, saturating
count_carry  output  CNT_W  accepted entries with in_banderas[1]=1, saturating

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=EMPTY; out_valid=0, in_ready=0.
  - out_c, out_banderas, sticky, count_ops, count_carry all 0.
  - Both buffer entries are zeroed.
  - in_ready rises at the first clk edge after rst_n deasserts. Anything on in_* while rst_n=0 is dropped.
- Handshake:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - Data and flags are sampled only on in_fire.
  - Once out_valid=1, out_c and out_banderas stay stable until out_fire.
- FSM states: EMPTY (0 entries), ONE (head valid), FULL (head + tail valid).
  - EMPTY: in_fire -> head<=in, go ONE.
  - ONE, in_fire only -> tail<=in, go FULL.
  - ONE, out_fire only -> go EMPTY.
  - ONE, in_fire & out_fire -> head<=in, stay ONE.
  - FULL: in_fire is impossible (in_ready=0). out_fire -> head<=tail, go ONE.
  - Registered outputs: out_valid = (state!=EMPTY); in_ready = (state!=FULL).
- Latency: an entry accepted at edge k is presented on out_* right after edge k (one cycle); throughput is 1 entry/cycle.
- Ordering: strict FIFO, no entry lost or duplicated. Flags are carried verbatim, never recomputed.
- Sticky: on in_fire, sticky <= sticky | in_banderas.
  - clr alone: sticky <= 0.
  - clr & in_fire in the same cycle: sticky <= in_banderas (old value discarded, new entry kept).
- Counters:
  - On in_fire, count_ops += 1.
  - If in_banderas[1]=1, count_carry += 1.
  - Each counter saturates at 2^CNT_W-1 and holds there.
  - clr zeroes both. clr & in_fire together: count_ops <= 1, count_carry <= in_banderas[1].
- clr does not affect the buffer, state or handshake.
- Reset mid-transfer: all entries are discarded immediately. No partial output may appear after release.

Test Plan:
- Reset then single entry: release rst_n, in_valid=1, in_c=4'hF, in_banderas=4'b1000, out_ready=1.
  - Required: in_ready=1 on the first edge; out_valid=1, out_c=F, out_banderas=1000 one cycle later; sticky=1000, count_ops=1.
- Backpressure: out_ready=0, offer 4'h3 (0000), 4'h0 (0100), 4'h5 (0000).
  - Required: first two accepted, in_ready=0 after the second, third held upstream.
  - Then out_ready=1: outputs appear in order 3, 0, 5; out_c stays stable while stalled.
- Streaming: in_valid=out_ready=1 for 20 cycles, incrementing data.
  - Required: state stays ONE, one entry out per cycle, no gaps, count_ops=20.
- Carry/sticky: inputs 8+8 (in_c=0, banderas=0111), then 1+1 (in_c=2, banderas=0000).
  - Required: count_carry=1, sticky=0111.
  - Then clr together with a 1000 input: sticky=1000, count_ops=1, count_carry=0.
- Saturation, CNT_W=4: 20 accepted entries all with C=1.
  - Required: count_ops=count_carry=15, both hold at 15.
- Async reset mid-operation: state FULL, drop rst_n between clock edges.
  - Required: out_valid=0 and counters=0 immediately, before the next edge.
  - After release: no stale entry appears, in_ready=1 after one edge.
